// File: rtl/inst_rom_arbiter_pkg.sv
// Shared definitions for the instruction ROM arbiter.
// Types, bus widths, ROM geometry and the address check helper.
package inst_rom_arbiter_pkg;

    localparam int InstAddrBus    = 32;
    localparam int InstBus        = 32;
    localparam int InstMemNum     = 131071;
    localparam int InstMemNumLog2 = 17;

    localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic ChipEnable  = 1'b1;
    localparam logic ChipDisable = 1'b0;

    typedef enum logic [1:0] {
        ArbIdle = 2'b00,
        ArbIf   = 2'b01,
        ArbDbg  = 2'b10
    } arb_state_e;

    typedef logic [3:0] arb_wait_t;

    // Misaligned word access or word index beyond the ROM depth.
    function automatic logic addr_bad(input logic [InstAddrBus-1:0] a);
        logic [InstAddrBus-3:0] word_idx;
        word_idx = a[InstAddrBus-1:2];
        return (a[1:0] != 2'b00) ||
               (word_idx >= (InstAddrBus-2)'(InstMemNum));
    endfunction

endpackage

// File: rtl/inst_rom_arbiter_pick.sv
// Combinational grant picker for the instruction ROM arbiter.
// INST_ARB_RR_EN selects round-robin instead of fixed IF priority.
module inst_arb_pick
    import inst_rom_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic       if_req,
    input  logic       dbg_req,
    input  arb_state_e state,
    input  arb_wait_t  wait_cnt,
    output logic       if_gnt,
    output logic       dbg_gnt
);

    logic dbg_first;

`ifdef INST_ARB_RR_EN
    // The counter is held at zero in round-robin mode.
    logic unused_wait;
    assign unused_wait = ^wait_cnt;
    assign dbg_first   = (state == ArbIf);
`else
    logic unused_state;
    assign unused_state = ^state;
    assign dbg_first    = (wait_cnt == arb_wait_t'(MAX_WAIT));
`endif

    // Resolve the request pair into a one-hot (or empty) grant.
    always_comb begin
        if_gnt  = 1'b0;
        dbg_gnt = 1'b0;
        case ({if_req, dbg_req})
            2'b11: begin
                if_gnt  = ~dbg_first;
                dbg_gnt = dbg_first;
            end
            2'b10:   if_gnt  = 1'b1;
            2'b01:   dbg_gnt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/inst_rom_arbiter.sv
// Shares the instruction ROM between the fetch (IF) and debug (DBG) ports.
// Build option: INST_ARB_RR_EN switches contention to round-robin.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   if_req,
    input  logic [InstAddrBus-1:0] if_addr,
    output logic                   if_gnt,
    output logic                   if_rvalid,
    output logic [InstBus-1:0]     if_inst,
    output logic                   if_err,
    output logic                   stallreq,

    input  logic                   dbg_req,
    input  logic [InstAddrBus-1:0] dbg_addr,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [InstBus-1:0]     dbg_inst,
    output logic                   dbg_err,

    output logic                   rom_ce,
    output logic [InstAddrBus-1:0] rom_addr,
    input  logic [InstBus-1:0]     rom_inst
);

    arb_state_e state_q, state_d;
    arb_wait_t  wait_cnt_q, wait_cnt_d;

    logic               if_rvalid_q, if_rvalid_d;
    logic [InstBus-1:0] if_inst_q, if_inst_d;
    logic               if_err_q, if_err_d;

    logic               dbg_rvalid_q, dbg_rvalid_d;
    logic [InstBus-1:0] dbg_inst_q, dbg_inst_d;
    logic               dbg_err_q, dbg_err_d;

    logic                   pick_if, pick_dbg;
    logic                   any_gnt;
    logic [InstAddrBus-1:0] sel_addr;
    logic                   sel_bad;
    logic [InstBus-1:0]     rsp_word;

    inst_arb_pick #(
        .MAX_WAIT (MAX_WAIT)
    ) u_pick (
        .if_req   (if_req),
        .dbg_req  (dbg_req),
        .state    (state_q),
        .wait_cnt (wait_cnt_q),
        .if_gnt   (pick_if),
        .dbg_gnt  (pick_dbg)
    );

    // Grants, stall and ROM drive; everything is held quiet during reset.
    always_comb begin
        if_gnt   = rst & pick_if;
        dbg_gnt  = rst & pick_dbg;
        any_gnt  = if_gnt | dbg_gnt;
        stallreq = rst & if_req & ~if_gnt;
        sel_addr = if_gnt ? if_addr : dbg_addr;
        sel_bad  = addr_bad(sel_addr);
        rom_ce   = ChipDisable;
        rom_addr = '0;
        if (any_gnt && !sel_bad) begin
            rom_ce   = ChipEnable;
            rom_addr = sel_addr;
        end
        rsp_word = sel_bad ? ZeroWord : rom_inst;
    end

    // Next state, starvation counter and response registers.
    always_comb begin
        state_d = ArbIdle;
        if (if_gnt) begin
            state_d = ArbIf;
        end else if (dbg_gnt) begin
            state_d = ArbDbg;
        end

        wait_cnt_d = '0;
`ifndef INST_ARB_RR_EN
        if (dbg_req && !dbg_gnt) begin
            if (wait_cnt_q == arb_wait_t'(MAX_WAIT)) begin
                wait_cnt_d = wait_cnt_q;
            end else begin
                wait_cnt_d = wait_cnt_q + 4'd1;
            end
        end
`endif

        if_rvalid_d = if_gnt;
        if_err_d    = if_gnt & sel_bad;
        if_inst_d   = if_gnt ? rsp_word : if_inst_q;

        dbg_rvalid_d = dbg_gnt;
        dbg_err_d    = dbg_gnt & sel_bad;
        dbg_inst_d   = dbg_gnt ? rsp_word : dbg_inst_q;
    end

    // FSM, counter and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ArbIdle;
            wait_cnt_q   <= '0;
            if_rvalid_q  <= 1'b0;
            if_inst_q    <= ZeroWord;
            if_err_q     <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            dbg_inst_q   <= ZeroWord;
            dbg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            if_inst_q    <= if_inst_d;
            if_err_q     <= if_err_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_inst_q   <= dbg_inst_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

    // A reset landing right after a grant cancels the pending response.
    assign if_rvalid  = if_rvalid_q & rst;
    assign if_err     = if_err_q & rst;
    assign if_inst    = if_inst_q;
    assign dbg_rvalid = dbg_rvalid_q & rst;
    assign dbg_err    = dbg_err_q & rst;
    assign dbg_inst   = dbg_inst_q;

endmodule
